// File: rtl/epoch_framer_pkg.sv
// Shared types for the epoch framer slice.
//   DATA_W     : default sample width
//   sample_t   : one ADC sample
//   rd_state_t : read-side FSM states
//   bank_sel_t : ping-pong bank selector
package framer_pkg;

  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    STREAM
  } rd_state_t;

  typedef logic bank_sel_t;

endpackage

// File: rtl/epoch_framer_if.sv
// Valid/ready stream carrying epochs to the feature/FFT stage.
//   m_tdata  : sample beat
//   m_tvalid : beat valid
//   m_tready : downstream ready
//   m_tlast  : final beat of an epoch
// master = framer side, slave = consumer side.
interface epoch_framer_if #(
  parameter int DATA_W = framer_pkg::DATA_W
);

  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_tlast;

  modport master (
    output m_tdata,
    output m_tvalid,
    output m_tlast,
    input  m_tready
  );

  modport slave (
    input  m_tdata,
    input  m_tvalid,
    input  m_tlast,
    output m_tready
  );

endinterface

// File: rtl/frame_bank_ram.sv
// Simple dual-port RAM holding both ping-pong banks, addressed {bank, ptr}.
//   clk   : clock
//   we    : write enable, waddr/wdata : write port
//   re    : read enable,  raddr       : read address
//   rdata : read data, valid one cycle after re
// Depth is rounded up to a power of two so {bank, ptr} maps directly.
module frame_bank_ram #(
  parameter int DATA_W = framer_pkg::DATA_W,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/epoch_framer.sv
// Captures one sample per rising edge of sample_clk, gathers WINDOW_LEN
// samples per epoch into a two-bank buffer and streams completed epochs.
//   clk, rst_n  : clock, async active-low reset
//   sample_in   : sample, taken on the sample_clk rising edge
//   sample_clk  : sampler strobe (synchronous to clk)
//   m           : epoch stream (master side)
//   frame_idx   : index of the epoch being / next to be streamed (wraps)
//   overflow    : one-cycle pulse per dropped sample
//   drop_count  : saturating count of dropped samples
module epoch_framer
  import framer_pkg::*;
#(
  parameter int DATA_W     = framer_pkg::DATA_W,
  parameter int WINDOW_LEN = 256,
  parameter int IDX_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_clk,
  epoch_framer_if.master    m,
  output logic [IDX_W-1:0]  frame_idx,
  output logic              overflow,
  output logic [IDX_W-1:0]  drop_count
);

  localparam int              PTR_W    = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(WINDOW_LEN - 1);

  logic              sclk_d;
  logic              cap;
  logic              drop;
  logic              wr_en;
  logic              wr_wrap;
  bank_sel_t         wr_bank;
  bank_sel_t         rd_bank;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_addr_ptr;
  logic [1:0]        bank_full;
  logic [1:0]        bank_full_nxt;
  rd_state_t         state;
  rd_state_t         state_nxt;
  logic              rd_en;
  logic              load;
  logic              hs;
  logic              hs_mid;
  logic              hs_last;
  logic [DATA_W-1:0] ram_rdata;

  // ---------------- capture / write side ----------------
  // sclk_d resets high so a strobe already asserted at reset release is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sclk_d <= 1'b1;
    else        sclk_d <= sample_clk;
  end

  assign cap     = sample_clk & ~sclk_d;
  // Decided on registered bank_full: a bank freed this cycle is still seen full.
  assign drop    = cap & bank_full[wr_bank];
  assign wr_en   = cap & ~bank_full[wr_bank];
  assign wr_wrap = wr_en & (wr_ptr == LAST_PTR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      wr_bank    <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      overflow <= drop;
      if (drop && (drop_count != '1)) drop_count <= drop_count + 1'b1;
      if (wr_wrap) begin
        wr_ptr  <= '0;
        wr_bank <= ~wr_bank;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  // Writer sets and reader clears; they never target the same bank in one cycle.
  always_comb begin
    bank_full_nxt = bank_full;
    if (wr_wrap) bank_full_nxt[wr_bank] = 1'b1;
    if (hs_last) bank_full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bank_full <= '0;
    else        bank_full <= bank_full_nxt;
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bank_full[rd_bank]) state_nxt = FETCH;
      FETCH:   state_nxt = STREAM;
      STREAM: begin
        if (hs_last)     state_nxt = IDLE;
        else if (hs_mid) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_en       = 1'b0;
    load        = 1'b0;
    hs          = 1'b0;
    hs_mid      = 1'b0;
    hs_last     = 1'b0;
    rd_addr_ptr = rd_ptr;
    unique case (state)
      IDLE:   rd_en = bank_full[rd_bank];
      FETCH:  load  = 1'b1;
      STREAM: begin
        hs          = m.m_tvalid & m.m_tready;
        hs_mid      = hs & ~m.m_tlast;
        hs_last     = hs & m.m_tlast;
        // Next beat's read is issued alongside the handshake that advances rd_ptr.
        rd_en       = hs_mid;
        rd_addr_ptr = rd_ptr + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      rd_bank    <= 1'b0;
      frame_idx  <= '0;
      m.m_tdata  <= '0;
      m.m_tvalid <= 1'b0;
      m.m_tlast  <= 1'b0;
    end else begin
      if (load) begin
        m.m_tdata  <= ram_rdata;
        m.m_tvalid <= 1'b1;
        m.m_tlast  <= (rd_ptr == LAST_PTR);
      end
      if (hs_mid) begin
        rd_ptr     <= rd_ptr + 1'b1;
        m.m_tvalid <= 1'b0;
      end
      if (hs_last) begin
        rd_ptr     <= '0;
        rd_bank    <= ~rd_bank;
        frame_idx  <= frame_idx + 1'b1;
        m.m_tvalid <= 1'b0;
        m.m_tlast  <= 1'b0;
      end
    end
  end

  frame_bank_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (PTR_W + 1)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr ({wr_bank, wr_ptr}),
    .wdata (sample_in),
    .re    (rd_en),
    .raddr ({rd_bank, rd_addr_ptr}),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_epoch_framer.sv
`timescale 1ns/1ps
module tb_epoch_framer;

  logic        clk;
  logic        rst_n;
  logic [31:0] sample_in;
  logic        sample_clk;
  logic [15:0] frame_idx;
  logic        overflow;
  logic [15:0] drop_count;

  epoch_framer_if #(.DATA_W(32)) m_if ();

  epoch_framer #(
    .DATA_W     (32),
    .WINDOW_LEN (4),
    .IDX_W      (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_in  (sample_in),
    .sample_clk (sample_clk),
    .m          (m_if),
    .frame_idx  (frame_idx),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int ovf_cnt = 0;
  int stall_err = 0;

  logic [31:0] bd[$];
  logic        bl[$];
  logic [15:0] bf[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic exp_beat(input int i, input logic [31:0] d, input logic l, input logic [15:0] f);
    if (i < bd.size()) begin
      chk($sformatf("beat%0d_data", i), bd[i], d);
      chk($sformatf("beat%0d_last", i), 32'(bl[i]), 32'(l));
      chk($sformatf("beat%0d_frame", i), 32'(bf[i]), 32'(f));
    end else begin
      chk($sformatf("beat%0d_present", i), bd.size(), i + 1);
    end
  endtask

  task automatic strobe(input logic [31:0] v);
    @(negedge clk);
    sample_in  = v;
    sample_clk = 1'b1;
    repeat (5) @(negedge clk);
    sample_clk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k;
    k = 0;
    while (bd.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_beats", bd.size(), n);
  endtask

  // Monitor: records handshakes, counts overflow cycles, checks stall stability.
  initial begin : mon
    logic        pv;
    logic [31:0] pd;
    logic        pl;
    pv = 1'b0;
    pd = '0;
    pl = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        if (pv && !(m_if.m_tvalid && m_if.m_tdata == pd && m_if.m_tlast == pl))
          stall_err++;
        if (overflow) ovf_cnt++;
        if (m_if.m_tvalid && m_if.m_tready) begin
          bd.push_back(m_if.m_tdata);
          bl.push_back(m_if.m_tlast);
          bf.push_back(frame_idx);
        end
        pv = m_if.m_tvalid && !m_if.m_tready;
        pd = m_if.m_tdata;
        pl = m_if.m_tlast;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected self-termination");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int k;
    logic [3:0] pat;
    pat = 4'b1001;

    // Reset with the stale strobe held high through release.
    rst_n         = 1'b0;
    sample_clk    = 1'b1;
    sample_in     = 32'hDEAD;
    m_if.m_tready = 1'b0;
    #2;
    chk("rst_tdata", m_if.m_tdata, 0);
    chk("rst_tvalid", 32'(m_if.m_tvalid), 0);
    chk("rst_tlast", 32'(m_if.m_tlast), 0);
    chk("rst_frame_idx", 32'(frame_idx), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_drop_count", 32'(drop_count), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    sample_clk = 1'b0;
    repeat (4) @(negedge clk);

    // Basic epoch with ready held high; 0xDEAD must never appear.
    m_if.m_tready = 1'b1;
    strobe(32'h11); strobe(32'h22); strobe(32'h33); strobe(32'h44);
    wait_beats(4, 40);
    exp_beat(0, 32'h11, 1'b0, 16'd0);
    exp_beat(1, 32'h22, 1'b0, 16'd0);
    exp_beat(2, 32'h33, 1'b0, 16'd0);
    exp_beat(3, 32'h44, 1'b1, 16'd0);
    chk("basic_frame_idx", 32'(frame_idx), 1);
    chk("basic_ovf_cnt", ovf_cnt, 0);

    // Stall mid-epoch with ready pattern 1,0,0,1.
    m_if.m_tready = 1'b0;
    strobe(32'h55); strobe(32'h66); strobe(32'h77); strobe(32'h88);
    k = 0;
    while (bd.size() < 8 && k < 100) begin
      @(negedge clk);
      m_if.m_tready = pat[k % 4];
      k++;
    end
    chk("stall_beats", bd.size(), 8);
    exp_beat(4, 32'h55, 1'b0, 16'd1);
    exp_beat(5, 32'h66, 1'b0, 16'd1);
    exp_beat(6, 32'h77, 1'b0, 16'd1);
    exp_beat(7, 32'h88, 1'b1, 16'd1);
    chk("stall_stability", stall_err, 0);

    // Backpressure: 12 strobes with ready low, last 4 dropped.
    @(negedge clk);
    m_if.m_tready = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 1; i <= 12; i++) strobe(32'h100 + 32'(i));
    chk("bp_drop_count", 32'(drop_count), 4);
    chk("bp_ovf_cnt", ovf_cnt, 4);
    chk("bp_no_beats", bd.size(), 8);
    m_if.m_tready = 1'b1;
    wait_beats(16, 60);
    for (int i = 0; i < 8; i++)
      exp_beat(8 + i, 32'h101 + 32'(i), (i % 4) == 3, (i < 4) ? 16'd2 : 16'd3);
    repeat (30) @(negedge clk);
    chk("bp_no_extra_beats", bd.size(), 16);
    chk("bp_frame_idx", 32'(frame_idx), 4);

    // Freeing collision: capture in the cycle the last handshake frees wr_bank.
    m_if.m_tready = 1'b0;
    for (int i = 1; i <= 8; i++) strobe(32'h200 + 32'(i));
    m_if.m_tready = 1'b1;
    k = 0;
    while (bd.size() < 19 && k < 50) begin
      @(negedge clk);
      k++;
    end
    m_if.m_tready = 1'b0;
    k = 0;
    while (!(m_if.m_tvalid && m_if.m_tlast) && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("coll_setup", 32'(m_if.m_tvalid && m_if.m_tlast), 1);
    m_if.m_tready = 1'b1;
    sample_in     = 32'h2FF;
    sample_clk    = 1'b1;
    @(negedge clk);
    #1;
    chk("coll_overflow", 32'(overflow), 1);
    repeat (3) @(negedge clk);
    sample_clk = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 9; i <= 12; i++) strobe(32'h200 + 32'(i));
    wait_beats(28, 60);
    for (int i = 0; i < 12; i++)
      exp_beat(16 + i, 32'h201 + 32'(i), (i % 4) == 3, 16'(4 + i / 4));
    chk("coll_drop_count", 32'(drop_count), 5);
    chk("coll_ovf_cnt", ovf_cnt, 5);
    chk("coll_frame_idx", 32'(frame_idx), 7);

    // Async reset mid-epoch, asserted between clock edges.
    m_if.m_tready = 1'b0;
    strobe(32'h301); strobe(32'h302); strobe(32'h303); strobe(32'h304);
    chk("pre_rst_tvalid", 32'(m_if.m_tvalid), 1);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_tvalid", 32'(m_if.m_tvalid), 0);
    chk("arst_tdata", m_if.m_tdata, 0);
    chk("arst_tlast", 32'(m_if.m_tlast), 0);
    chk("arst_frame_idx", 32'(frame_idx), 0);
    chk("arst_drop_count", 32'(drop_count), 0);
    chk("arst_overflow", 32'(overflow), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_if.m_tready = 1'b1;
    strobe(32'h401); strobe(32'h402); strobe(32'h403); strobe(32'h404);
    wait_beats(32, 60);
    for (int i = 0; i < 4; i++)
      exp_beat(28 + i, 32'h401 + 32'(i), i == 3, 16'd0);
    chk("post_rst_frame_idx", 32'(frame_idx), 1);
    chk("post_rst_drop_count", 32'(drop_count), 0);
    chk("final_stall_stability", stall_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
